// File: rtl/gray_pkg.sv
// Shared constants for the sequential Gray-to-binary decoder:
// FSM state encodings and the default word width.
package gray_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam int GRAY_W = 6;

endpackage

// File: rtl/gray_to_binary_seq_if.sv
// Valid/ready bus between a Gray-coded source, the decoder and a binary consumer.
// The decoder takes the slave side; the source/consumer pair drives the master side.
interface gray_to_binary_seq_if
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] g;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] b;
   logic             busy;

   modport master (
      output in_valid,
      output g,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  b,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  g,
      input  out_ready,
      output in_ready,
      output out_valid,
      output b,
      output busy
   );

endinterface

// File: rtl/gray_to_binary_seq.sv
// Sequential Gray-to-binary decoder: one bit per clock, MSB first, using a running XOR.
// The critical path is a single XOR plus an index mux regardless of WIDTH.
module gray_to_binary_seq
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W
) (
   input  logic                clk,
   input  logic                rst_n,
   gray_to_binary_seq_if.slave bus
);

   localparam int                IDX_W   = $clog2(WIDTH);
   localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_g;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_b;
   logic             r_p;
   logic [IDX_W-1:0] r_idx;
   logic             r_out_valid;
   logic             r_busy;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_p_next;
   logic             w_last;
   logic [WIDTH-1:0] w_acc_next;

   // Ready is combinational so a HOLD retire and a new accept can share one edge
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         IDLE:    w_in_ready = 1'b1;
         HOLD:    w_in_ready = bus.out_ready;
         default: w_in_ready = 1'b0;
      endcase
   end

   assign w_accept = bus.in_valid && w_in_ready;
   assign w_p_next = r_p ^ r_g[r_idx];
   assign w_last   = (r_idx == IDX_ZERO);

   // Accumulator with the current bit replaced by the running parity
   always_comb begin
      w_acc_next        = r_acc;
      w_acc_next[r_idx] = w_p_next;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_g         <= {WIDTH{1'b0}};
         r_acc       <= {WIDTH{1'b0}};
         r_b         <= {WIDTH{1'b0}};
         r_p         <= 1'b0;
         r_idx       <= IDX_ZERO;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_g     <= bus.g;
                  r_acc   <= {WIDTH{1'b0}};
                  r_p     <= 1'b0;
                  r_idx   <= IDX_TOP;
                  r_busy  <= 1'b1;
                  r_state <= CONV;
               end
            end
            CONV: begin
               r_acc <= w_acc_next;
               r_p   <= w_p_next;
               if (w_last) begin
                  r_b         <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= HOLD;
               end else begin
                  r_idx <= r_idx - IDX_ONE;
               end
            end
            HOLD: begin
               // A retire with a waiting word skips IDLE entirely
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (bus.in_valid) begin
                     r_g     <= bus.g;
                     r_acc   <= {WIDTH{1'b0}};
                     r_p     <= 1'b0;
                     r_idx   <= IDX_TOP;
                     r_busy  <= 1'b1;
                     r_state <= CONV;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.b         = r_b;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Directed and round-trip bench for gray_to_binary_seq with a queue scoreboard.
// Inputs change and outputs are sampled on the falling edge.
module tb_gray_to_binary_seq;
   import gray_pkg::*;

   localparam int W = GRAY_W;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   gray_to_binary_seq_if #(.WIDTH(W)) gif ();

   gray_to_binary_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (gif)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] sb_q[$];

   function automatic logic [W-1:0] bin2gray(input logic [W-1:0] x);
      return x ^ (x >> 1);
   endfunction

   function automatic logic [W-1:0] prefix_xor(input logic [W-1:0] gv);
      logic         acc;
      logic [W-1:0] r;
      acc = 1'b0;
      r   = '0;
      for (int i = W - 1; i >= 0; i--) begin
         acc  = acc ^ gv[i];
         r[i] = acc;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge while the DUT is idle; returns on the falling edge after accept
   task automatic send(input string tag, input logic [W-1:0] gv);
      gif.g        = gv;
      gif.in_valid = 1'b1;
      #1;
      chk({tag, "_in_ready"}, gif.in_ready, 1);
      @(posedge clk);
      sb_q.push_back(prefix_xor(gv));
      @(negedge clk);
      gif.in_valid = 1'b0;
      gif.g        = ~gv;
   endtask

   task automatic wait_result(output int cycles, output int busy_cnt);
      cycles   = 0;
      busy_cnt = 0;
      while (!gif.out_valid && cycles < 20) begin
         if (gif.busy) busy_cnt++;
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic retire(input string tag);
      chk({tag, "_out_valid"}, gif.out_valid, 1);
      chk({tag, "_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) chk({tag, "_b"}, gif.b, sb_q.pop_front());
      gif.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      gif.out_ready = 1'b0;
      chk({tag, "_idle_ready"}, gif.in_ready, 1);
      chk({tag, "_idle_valid"}, gif.out_valid, 0);
   endtask

   task automatic decode(input string tag, input logic [W-1:0] gv);
      int c;
      int bc;
      send(tag, gv);
      wait_result(c, bc);
      chk({tag, "_latency"}, c, W);
      chk({tag, "_busy_cycles"}, bc, W);
      retire(tag);
   endtask

   initial begin
      int c;
      int bc;
      int seen;
      int nx;
      int nrx;
      int guard;

      rst_n         = 1'b1;
      gif.in_valid  = 1'b0;
      gif.out_ready = 1'b0;
      gif.g         = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", gif.in_ready, 1);
      chk("rst_out_valid", gif.out_valid, 0);
      chk("rst_busy", gif.busy, 0);
      chk("rst_b", gif.b, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      decode("basic", 6'b111011);
      decode("zero", 6'b000000);
      decode("msb", 6'b100000);
      decode("ones", 6'b111111);

      // Backpressure: result must stay put while the consumer stalls
      send("bp", 6'b010110);
      wait_result(c, bc);
      chk("bp_latency", c, W);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_b_stable", gif.b, 6'b011011);
         chk("bp_out_valid", gif.out_valid, 1);
         chk("bp_in_ready", gif.in_ready, 0);
      end
      retire("bp");

      // Back-to-back: retire and accept on the same edge
      send("b2b", 6'b111011);
      wait_result(c, bc);
      chk("b2b_b", gif.b, 6'b101101);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      gif.out_ready = 1'b1;
      gif.in_valid  = 1'b1;
      gif.g         = 6'b101001;
      #1;
      chk("b2b_in_ready", gif.in_ready, 1);
      @(posedge clk);
      sb_q.push_back(6'b110001);
      @(negedge clk);
      gif.in_valid  = 1'b0;
      gif.out_ready = 1'b0;
      gif.g         = '0;
      chk("b2b_valid_drop", gif.out_valid, 0);
      chk("b2b_busy", gif.busy, 1);
      wait_result(c, bc);
      chk("b2b_latency", c, W);
      retire("b2b2");

      // Reset three cycles into CONV
      send("rst_mid", 6'b111111);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("rst_mid_busy_before", gif.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", gif.out_valid, 0);
      chk("rst_mid_b", gif.b, 0);
      chk("rst_mid_in_ready", gif.in_ready, 1);
      chk("rst_mid_busy", gif.busy, 0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (gif.out_valid) seen++;
      end
      chk("rst_mid_no_pulse", seen, 0);
      chk("rst_mid_b_after", gif.b, 0);

      // Round trip over every code with random consumer stalls
      nx    = 0;
      nrx   = 0;
      guard = 0;
      while (nrx < 64 && guard < 2000) begin
         gif.out_ready = 1'($urandom_range(0, 1));
         if (nx < 64) begin
            gif.in_valid = 1'b1;
            gif.g        = bin2gray(nx[W-1:0]);
         end else begin
            gif.in_valid = 1'b0;
         end
         #1;
         if (gif.out_valid && gif.out_ready) begin
            if (sb_q.size() > 0) chk("rt_b", gif.b, sb_q.pop_front());
            else chk("rt_depth", sb_q.size(), 1);
            nrx++;
         end
         if (gif.in_valid && gif.in_ready) begin
            sb_q.push_back(nx[W-1:0]);
            nx++;
         end
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      gif.in_valid  = 1'b0;
      gif.out_ready = 1'b0;
      chk("rt_count", nrx, 64);
      chk("rt_sent", nx, 64);
      chk("rt_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
